// File: rtl/calc1_req_driver.sv
// Single-port calc1 request initiator: accepts a transaction upstream, drives the two-cycle
// request, waits for out_resp with a timeout, then returns the result downstream.
module calc1_req_driver #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CMD_W   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic              c_clk,
    input  logic              reset_n,

    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [CMD_W-1:0]  tx_cmd,
    input  logic [DATA_W-1:0] tx_op1,
    input  logic [DATA_W-1:0] tx_op2,

    output logic [CMD_W-1:0]  req_cmd_in,
    output logic [DATA_W-1:0] req_data_in,
    input  logic [1:0]        out_resp,
    input  logic [DATA_W-1:0] out_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,

    output logic              err_spurious,
    output logic              busy,
    output logic [15:0]       txn_count
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StOp2,
        StWait,
        StDone
    } state_e;

    localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [CMD_W-1:0]    req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                err_spurious_q, err_spurious_d;
    logic [15:0]         txn_count_q, txn_count_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                resp_seen;

    assign resp_seen = (out_resp != 2'd0);

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            op2_q          <= '0;
            req_cmd_q      <= '0;
            req_data_q     <= '0;
            rsp_resp_q     <= '0;
            rsp_data_q     <= '0;
            rsp_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            txn_count_q    <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            op2_q          <= op2_d;
            req_cmd_q      <= req_cmd_d;
            req_data_q     <= req_data_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_data_q     <= rsp_data_d;
            rsp_timeout_q  <= rsp_timeout_d;
            err_spurious_q <= err_spurious_d;
            txn_count_q    <= txn_count_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op2_d          = op2_q;
        req_cmd_d      = '0;
        req_data_d     = '0;
        rsp_resp_d     = rsp_resp_q;
        rsp_data_d     = rsp_data_q;
        rsp_timeout_d  = rsp_timeout_q;
        txn_count_d    = txn_count_q;
        cnt_d          = cnt_q;
        // A response outside WAIT is only flagged; it never alters state or data.
        err_spurious_d = err_spurious_q | (resp_seen && (state_q != StWait));

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    op2_d         = tx_op2;
                    rsp_resp_d    = '0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b0;
                    if (tx_cmd != '0) begin
                        // Request outputs are registered, so the CMD beat is loaded here.
                        state_d    = StCmd;
                        req_cmd_d  = tx_cmd;
                        req_data_d = tx_op1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StCmd: begin
                state_d    = StOp2;
                req_data_d = op2_q;
            end
            StOp2: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                cnt_d = cnt_q + TO_W'(1);
                if (resp_seen) begin
                    state_d       = StDone;
                    rsp_resp_d    = out_resp;
                    rsp_data_d    = out_data;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == LastCnt) begin
                    state_d       = StDone;
                    rsp_resp_d    = '0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    if (txn_count_q != 16'hFFFF) begin
                        txn_count_d = txn_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_ready     = (state_q == StIdle);
    assign rsp_valid    = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign req_cmd_in   = req_cmd_q;
    assign req_data_in  = req_data_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign err_spurious = err_spurious_q;
    assign txn_count    = txn_count_q;

endmodule
